// File: rtl/dmem_wait_state_model.sv
// Data-memory slave with programmable wait states and range checking.
// Define DMEM_RANDOM_WAIT_EN for LFSR-driven wait counts.
module dmem_wait_state_model #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] OOR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_rd_en,
  input  logic        req_wr_en,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [3:0]    cnt;
  logic [3:0]    cnt_load;
  logic          req;
  logic          sample;
  logic          go_resp;
  logic          req_oor;

  logic          rd_q;
  logic          wr_q;
  logic          oor_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;

  logic          cur_rd;
  logic          cur_wr;
  logic          cur_oor;
  logic [AW-1:0] cur_idx;
  logic [31:0]   cur_wdata;
  logic [3:0]    cur_be;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   old_word;
  logic [31:0]   new_word;
  logic          addr_unused;

  assign req     = req_rd_en | req_wr_en;
  assign sample  = (state == IDLE) && req;
  assign req_oor = {2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS);
  assign addr_unused = &{1'b0, req_addr[1:0]};

`ifdef DMEM_RANDOM_WAIT_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 8'hA5;
    end else if (sample) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign cnt_load = 4'(32'(lfsr[3:0]) % (WAIT_CYCLES + 1));
`else
  assign cnt_load = 4'(WAIT_CYCLES);
`endif

  // With zero waits the response is entered on the sample edge itself,
  // so the array access uses the live request rather than the latches.
  always_comb begin
    cur_rd    = rd_q;
    cur_wr    = wr_q;
    cur_oor   = oor_q;
    cur_idx   = idx_q;
    cur_wdata = wdata_q;
    cur_be    = be_q;
    if (state == IDLE) begin
      cur_rd    = req_rd_en;
      cur_wr    = req_wr_en;
      cur_oor   = req_oor;
      cur_idx   = req_addr[AW+1:2];
      cur_wdata = req_wdata;
      cur_be    = req_be;
    end
  end

  assign go_resp = (sample && (cnt_load == 4'd0)) ||
                   ((state == WAIT) && (cnt == 4'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req) begin
          state_nxt = (cnt_load == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rsp_ready = (state == RESP);
    rsp_err   = (state == RESP) && oor_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      oor_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (sample) begin
      cnt     <= cnt_load;
      rd_q    <= req_rd_en;
      wr_q    <= req_wr_en;
      oor_q   <= req_oor;
      idx_q   <= req_addr[AW+1:2];
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end else if (state == WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign old_word = mem[cur_idx];

  always_comb begin
    new_word = old_word;
    for (int i = 0; i < 4; i++) begin
      if (cur_be[i]) begin
        new_word[8*i +: 8] = cur_wdata[8*i +: 8];
      end
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (rst_n && go_resp && cur_wr && !cur_oor) begin
      mem[cur_idx] <= new_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
    end else if (go_resp && cur_rd) begin
      rsp_rdata <= cur_oor ? OOR_RDATA : old_word;
    end
  end

endmodule

// File: tb/tb_dmem_wait_state_model.sv
// Testbench for dmem_wait_state_model: vector table, hand sequences,
// and random traffic against a word-array reference model.
module tb_dmem_wait_state_model;

`ifdef DMEM_RANDOM_WAIT_EN
  localparam int W = 3;
`else
  localparam int W = 2;
`endif
  localparam int DEPTH = 1024;
  localparam logic [31:0] OOR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_rd_en = 1'b0;
  logic        req_wr_en = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  dmem_wait_state_model #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(W),
    .OOR_RDATA(OOR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_rd_en(req_rd_en),
    .req_wr_en(req_wr_en),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_be(req_be),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  int tests = 0;
  int fails = 0;

  logic [31:0] mm [DEPTH];
  logic [31:0] m_rdata = '0;
  logic [7:0]  m_lfsr = 8'hA5;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int m_next_lat();
    int l;
`ifdef DMEM_RANDOM_WAIT_EN
    l = (int'(m_lfsr[3:0]) % (W + 1)) + 1;
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`else
    l = W + 1;
`endif
    return l;
  endfunction

  task automatic m_apply(input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be,
                         output logic [31:0] erd, output logic eerr);
    int  idx;
    logic oor;
    idx = int'(addr[31:2]);
    oor = (idx >= DEPTH);
    if (rd) m_rdata = oor ? OOR : mm[idx];
    if (wr && !oor) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mm[idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
    erd  = m_rdata;
    eerr = oor;
  endtask

  task automatic do_req(input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be,
                        output int lat, output logic [31:0] rdata,
                        output logic err);
    req_rd_en = rd;
    req_wr_en = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (rsp_ready) break;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    req_rd_en = 1'b0;
    req_wr_en = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_pulse_width", 32'(rsp_ready), 32'd0);
  endtask

  task automatic run_op(input string nm, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be,
                        output logic [31:0] rdata, output logic err,
                        output int lat);
    int          elat;
    logic [31:0] erd;
    logic        eerr;
    elat = m_next_lat();
    m_apply(rd, wr, addr, wdata, be, erd, eerr);
    do_req(rd, wr, addr, wdata, be, lat, rdata, err);
    chk({nm, "_lat"}, 32'(lat), 32'(elat));
    chk({nm, "_rdata"}, rdata, erd);
    chk({nm, "_err"}, 32'(err), 32'(eerr));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_lfsr  = 8'hA5;
    m_rdata = '0;
    @(posedge clk);
    #1;
  endtask

  vec_t        vt[$];
  logic [31:0] rd_v;
  logic        err_v;
  int          lat_v;
  int          cnt_rdy;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt.push_back('{1'b0, 1'b1, 32'h100,  32'hCAFEF00D, 4'hF, 32'h0,        1'b0});
    vt.push_back('{1'b1, 1'b0, 32'h100,  32'h0,        4'h0, 32'hCAFEF00D, 1'b0});
    vt.push_back('{1'b0, 1'b1, 32'h102,  32'h11223344, 4'h5, 32'hCAFEF00D, 1'b0});
    vt.push_back('{1'b1, 1'b0, 32'h100,  32'h0,        4'h0, 32'hCA22F044, 1'b0});
    vt.push_back('{1'b0, 1'b1, 32'h000,  32'hA5A5A5A5, 4'hF, 32'hCA22F044, 1'b0});
    vt.push_back('{1'b0, 1'b1, 32'h1000, 32'h12345678, 4'hF, 32'hCA22F044, 1'b1});
    vt.push_back('{1'b1, 1'b0, 32'h1000, 32'h0,        4'h0, 32'hDEADBEEF, 1'b1});
    vt.push_back('{1'b1, 1'b0, 32'h000,  32'h0,        4'h0, 32'hA5A5A5A5, 1'b0});
    vt.push_back('{1'b0, 1'b1, 32'h100,  32'hCAFEF00D, 4'hF, 32'hA5A5A5A5, 1'b0});
    vt.push_back('{1'b1, 1'b1, 32'h100,  32'h0,        4'hF, 32'hCAFEF00D, 1'b0});
    vt.push_back('{1'b1, 1'b0, 32'h100,  32'h0,        4'h0, 32'h0,        1'b0});
    vt.push_back('{1'b0, 1'b1, 32'h100,  32'hFFFFFFFF, 4'h0, 32'h0,        1'b0});
    vt.push_back('{1'b1, 1'b0, 32'h100,  32'h0,        4'h0, 32'h0,        1'b0});
    vt.push_back('{1'b0, 1'b1, 32'hFFC,  32'h0BADF00D, 4'hF, 32'h0,        1'b0});
    vt.push_back('{1'b1, 1'b0, 32'hFFF,  32'h0,        4'h0, 32'h0BADF00D, 1'b0});

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(rsp_ready), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("idle_ready%0d", i), 32'(rsp_ready), 32'd0);
    end

    foreach (vt[i]) begin
      run_op($sformatf("vec%0d", i), vt[i].rd, vt[i].wr, vt[i].addr,
             vt[i].wdata, vt[i].be, rd_v, err_v, lat_v);
      chk($sformatf("vec%0d_tbl_rdata", i), rd_v, vt[i].exp_rdata);
      chk($sformatf("vec%0d_tbl_err", i), 32'(err_v), 32'(vt[i].exp_err));
    end

`ifndef DMEM_RANDOM_WAIT_EN
    // Reset during WAIT must abort the pending write
    run_op("pre200", 1'b0, 1'b1, 32'h200, 32'h11111111, 4'hF,
           rd_v, err_v, lat_v);
    req_wr_en = 1'b1;
    req_addr  = 32'h200;
    req_wdata = 32'h99999999;
    req_be    = 4'hF;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    req_wr_en = 1'b0;
    m_rdata = '0;
    chk("abort_rdata", rsp_rdata, 32'd0);
    cnt_rdy = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (rsp_ready) cnt_rdy++;
    end
    chk("abort_no_ready", 32'(cnt_rdy), 32'd0);
    run_op("post200", 1'b1, 1'b0, 32'h200, 32'h0, 4'h0, rd_v, err_v, lat_v);
    chk("abort_word", rd_v, 32'h11111111);

    // Request held high: responses spaced WAIT_CYCLES+2 apart
    begin
      int edges;
      int first;
      int second;
      edges = 0;
      first = -1;
      second = -1;
      req_rd_en = 1'b1;
      req_addr  = 32'h100;
      while (edges < 30 && second < 0) begin
        @(posedge clk);
        edges++;
        #1;
        if (rsp_ready) begin
          if (first < 0) first = edges;
          else second = edges;
        end
      end
      req_rd_en = 1'b0;
      @(posedge clk);
      #1;
      chk("b2b_first", 32'(first), 32'(W + 1));
      chk("b2b_period", 32'(second - first), 32'(W + 2));
      chk("b2b_rdata", rsp_rdata, mm[64]);
      m_rdata = mm[64];
    end
`endif

    // Random traffic against the model
    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("init%0d", i), 1'b0, 1'b1, 32'(i * 4),
             $urandom, 4'hF, rd_v, err_v, lat_v);
    end
    for (int i = 0; i < 150; i++) begin
      int          sel;
      int          op;
      logic [29:0] idx;
      sel = $urandom_range(0, 10);
      op  = $urandom_range(0, 2);
      if (sel < 8) idx = 30'(sel);
      else if (sel == 8) idx = 30'd1023;
      else if (sel == 9) idx = 30'd1024;
      else idx = 30'($urandom_range(1025, 32'h3FFF_FFFF));
      run_op($sformatf("rnd%0d", i), op != 1, op != 0,
             {idx, 2'($urandom_range(0, 3))}, $urandom,
             4'($urandom_range(0, 15)), rd_v, err_v, lat_v);
    end

`ifdef DMEM_RANDOM_WAIT_EN
    begin
      int lat_a[64];
      int mn;
      int mx;
      pulse_reset();
      mn = 99;
      mx = 0;
      for (int i = 0; i < 64; i++) begin
        run_op($sformatf("lfa%0d", i), 1'b1, 1'b0, 32'h100, 32'h0, 4'h0,
               rd_v, err_v, lat_a[i]);
        chk($sformatf("lfa%0d_range", i),
            32'(lat_a[i] >= 1 && lat_a[i] <= W + 1), 32'd1);
        if (lat_a[i] < mn) mn = lat_a[i];
        if (lat_a[i] > mx) mx = lat_a[i];
      end
      chk("lat_distinct", 32'(mx != mn), 32'd1);
      pulse_reset();
      for (int i = 0; i < 64; i++) begin
        run_op($sformatf("lfb%0d", i), 1'b1, 1'b0, 32'h100, 32'h0, 4'h0,
               rd_v, err_v, lat_v);
        chk($sformatf("lfb%0d_repeat", i), 32'(lat_v), 32'(lat_a[i]));
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
